multicycle_ctrl_param: RTL and testbench

- Parametrised next-generation multicycle controller for the accumulator CPU (AC/AC2 datapath, PC, IR, single memory port).
- Adds wider opcode space, a memory-ready wait handshake with timeout, conditional and absolute jumps, clear-AC, HALT with restart, and an illegal-opcode trap.
- Drives the same datapath control strobes as the existing controller.
- Sits between the instruction register/flags and the datapath/memory.

---
 rtl/multicycle_ctrl_param_if.sv | 40 ++++
 rtl/multicycle_ctrl_param.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_ctrl_param.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_param_if.sv
// Signal bundle between the multicycle controller and the IR/flags/datapath/memory side.
interface multicycle_ctrl_param_if #(
  parameter int OPW = 4
);
  logic [OPW-1:0] op_code;
  logic           zero_flag;
  logic           mem_ready;
  logic           run;
  logic           rd_mem;
  logic           wr_mem;
  logic           pc_on_adr;
  logic           ir_on_adr;
  logic           ld_ir;
  logic           ld_ac;
  logic           ld_acii;
  logic           ld_pc;
  logic           inc_pc;
  logic           clr_pc;
  logic           sel_acii;
  logic           sel_ir;
  logic           sel_zero;
  logic           source_ac;
  logic [1:0]     pass_add;
  logic           halted;
  logic           error;

  modport master (
    input  op_code, zero_flag, mem_ready, run,
    output rd_mem, wr_mem, pc_on_adr, ir_on_adr, ld_ir, ld_ac, ld_acii, ld_pc,
           inc_pc, clr_pc, sel_acii, sel_ir, sel_zero, source_ac, pass_add,
           halted, error
  );

  modport slave (
    output op_code, zero_flag, mem_ready, run,
    input  rd_mem, wr_mem, pc_on_adr, ir_on_adr, ld_ir, ld_ac, ld_acii, ld_pc,
           inc_pc, clr_pc, sel_acii, sel_ir, sel_zero, source_ac, pass_add,
           halted, error
  );
endinterface

// File: rtl/multicycle_ctrl_param.sv
// Multicycle controller for the accumulator CPU with memory-ready wait/timeout, jumps,
// HALT/run restart and an illegal-opcode trap.
//   state     | meaning
//   S_RESET   | clr_pc asserted for RESET_CYCLES cycles
//   S_FETCH   | read instruction at PC, wait for mem_ready
//   S_DECODE  | capture op_code into op_q
//   S_EXECUTE | drive strobes for op_q, memory ops wait for mem_ready
//   S_HALT    | idle until run
//   S_ERROR   | timeout or illegal opcode, held until reset
module multicycle_ctrl_param #(
  parameter int OPW          = 4,
  parameter int RESET_CYCLES = 1,
  parameter int WAIT_MAX     = 15,
  parameter int ILLEGAL_TRAP = 1
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_ctrl_param_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXECUTE, S_HALT, S_ERROR
  } state_t;

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int WCW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [RCW-1:0] RST_LAST   = RCW'(RESET_CYCLES - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_MAX);
  localparam bit             TIMEOUT_EN = (WAIT_MAX > 0);
  localparam bit             TRAP_EN    = (ILLEGAL_TRAP != 0);

  localparam logic [OPW-1:0] OP_LDA   = OPW'(0);
  localparam logic [OPW-1:0] OP_MOV   = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(2);
  localparam logic [OPW-1:0] OP_STA2  = OPW'(3);
  localparam logic [OPW-1:0] OP_STA   = OPW'(4);
  localparam logic [OPW-1:0] OP_JMP0  = OPW'(5);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(6);
  localparam logic [OPW-1:0] OP_STA_B = OPW'(7);
  localparam logic [OPW-1:0] OP_JZ    = OPW'(8);
  localparam logic [OPW-1:0] OP_JMP   = OPW'(9);
  localparam logic [OPW-1:0] OP_CLRA  = OPW'(10);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(11);
  localparam logic [OPW-1:0] OP_ILL   = OPW'(12);

  state_t         state;
  logic [RCW-1:0] rst_cnt;
  logic [WCW-1:0] wait_cnt;
  logic [OPW-1:0] op_q;
  logic           mem_op;
  logic           illegal;
  logic           timeout;

  assign mem_op  = (op_q == OP_LDA) || (op_q == OP_STA2) ||
                   (op_q == OP_STA) || (op_q == OP_STA_B);
  assign illegal = (op_q >= OP_ILL);
  // Only meaningful while a memory access is pending; the FSM checks it in those states only.
  assign timeout = TIMEOUT_EN && (wait_cnt == WAIT_LAST) && !bus.mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RESET;
      rst_cnt  <= '0;
      wait_cnt <= '0;
      op_q     <= '0;
    end else begin
      unique case (state)
        S_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state   <= S_FETCH;
            rst_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.mem_ready) begin
            state    <= S_DECODE;
            wait_cnt <= '0;
          end else if (timeout) begin
            state    <= S_ERROR;
            wait_cnt <= '0;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          op_q  <= bus.op_code;
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (mem_op) begin
            if (bus.mem_ready) begin
              state    <= S_FETCH;
              wait_cnt <= '0;
            end else if (timeout) begin
              state    <= S_ERROR;
              wait_cnt <= '0;
            end else if (TIMEOUT_EN) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else if (op_q == OP_HALT) begin
            state <= S_HALT;
          end else if (illegal && TRAP_EN) begin
            state <= S_ERROR;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          if (bus.run) state <= S_FETCH;
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
    end
  end

  always_comb begin
    bus.rd_mem    = 1'b0;
    bus.wr_mem    = 1'b0;
    bus.pc_on_adr = 1'b0;
    bus.ir_on_adr = 1'b0;
    bus.ld_ir     = 1'b0;
    bus.ld_ac     = 1'b0;
    bus.ld_acii   = 1'b0;
    bus.ld_pc     = 1'b0;
    bus.inc_pc    = 1'b0;
    bus.clr_pc    = 1'b0;
    bus.sel_acii  = 1'b0;
    bus.sel_ir    = 1'b0;
    bus.sel_zero  = 1'b0;
    bus.source_ac = 1'b0;
    bus.pass_add  = 2'b00;
    bus.halted    = 1'b0;
    bus.error     = 1'b0;
    unique case (state)
      S_RESET: bus.clr_pc = 1'b1;
      S_FETCH: begin
        bus.pc_on_adr = 1'b1;
        bus.rd_mem    = 1'b1;
        bus.ld_ir     = bus.mem_ready;
        bus.inc_pc    = bus.mem_ready;
      end
      S_EXECUTE: begin
        case (op_q)
          OP_LDA: begin
            bus.ir_on_adr = 1'b1;
            bus.rd_mem    = 1'b1;
            bus.ld_ac     = bus.mem_ready;
          end
          OP_MOV: bus.ld_acii = 1'b1;
          OP_ADD: begin
            bus.ld_acii  = 1'b1;
            bus.sel_acii = 1'b1;
            bus.pass_add = 2'b01;
          end
          OP_STA2: begin
            bus.ir_on_adr = 1'b1;
            bus.wr_mem    = 1'b1;
            bus.sel_acii  = 1'b1;
            bus.pass_add  = 2'b11;
          end
          OP_STA, OP_STA_B: begin
            bus.ir_on_adr = 1'b1;
            bus.wr_mem    = 1'b1;
          end
          OP_JMP0: bus.clr_pc = 1'b1;
          OP_SUB: begin
            bus.ld_ac     = 1'b1;
            bus.sel_acii  = 1'b1;
            bus.source_ac = 1'b1;
            bus.pass_add  = 2'b10;
          end
          OP_JZ: begin
            bus.ld_pc  = bus.zero_flag;
            bus.sel_ir = bus.zero_flag;
          end
          OP_JMP: begin
            bus.ld_pc  = 1'b1;
            bus.sel_ir = 1'b1;
          end
          OP_CLRA: begin
            bus.ld_ac    = 1'b1;
            bus.sel_zero = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT:  bus.halted = 1'b1;
      S_ERROR: bus.error  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_param.sv
// Bench for multicycle_ctrl_param: two instances (trap+timeout vs. NOP+no-timeout) checked
// cycle by cycle against an opcode strobe table and instruction timing rules.
module tb_multicycle_ctrl_param;
  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic [3:0] op_code   = 4'd0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       run       = 1'b0;
  int         n_tests   = 0;
  int         n_fail    = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_param_if #(.OPW(4)) bus_a ();
  multicycle_ctrl_param_if #(.OPW(4)) bus_b ();

  assign bus_a.op_code   = op_code;
  assign bus_a.zero_flag = zero_flag;
  assign bus_a.mem_ready = mem_ready;
  assign bus_a.run       = run;
  assign bus_b.op_code   = op_code;
  assign bus_b.zero_flag = zero_flag;
  assign bus_b.mem_ready = mem_ready;
  assign bus_b.run       = run;

  multicycle_ctrl_param #(.OPW(4), .RESET_CYCLES(3), .WAIT_MAX(15), .ILLEGAL_TRAP(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  multicycle_ctrl_param #(.OPW(4), .RESET_CYCLES(3), .WAIT_MAX(0), .ILLEGAL_TRAP(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  logic [17:0] va, vb;
  assign va = {bus_a.halted, bus_a.error, bus_a.rd_mem, bus_a.wr_mem, bus_a.pc_on_adr,
               bus_a.ir_on_adr, bus_a.ld_ir, bus_a.ld_ac, bus_a.ld_acii, bus_a.ld_pc,
               bus_a.inc_pc, bus_a.clr_pc, bus_a.sel_acii, bus_a.sel_ir, bus_a.sel_zero,
               bus_a.source_ac, bus_a.pass_add};
  assign vb = {bus_b.halted, bus_b.error, bus_b.rd_mem, bus_b.wr_mem, bus_b.pc_on_adr,
               bus_b.ir_on_adr, bus_b.ld_ir, bus_b.ld_ac, bus_b.ld_acii, bus_b.ld_pc,
               bus_b.inc_pc, bus_b.clr_pc, bus_b.sel_acii, bus_b.sel_ir, bus_b.sel_zero,
               bus_b.source_ac, bus_b.pass_add};

  localparam logic [17:0] HALTED = 18'h20000, ERR    = 18'h10000, RD     = 18'h08000;
  localparam logic [17:0] WR     = 18'h04000, PC_ADR = 18'h02000, IR_ADR = 18'h01000;
  localparam logic [17:0] LD_IR  = 18'h00800, LD_AC  = 18'h00400, LD_ACII = 18'h00200;
  localparam logic [17:0] LD_PC  = 18'h00100, INC    = 18'h00080, CLR    = 18'h00040;
  localparam logic [17:0] S_ACII = 18'h00020, S_IR   = 18'h00010, S_ZERO = 18'h00008;
  localparam logic [17:0] SRC_AC = 18'h00004, PA_ADD = 18'h00001, PA_SUB = 18'h00002;
  localparam logic [17:0] PA_AC2 = 18'h00003;
  localparam logic [17:0] FETCH_BASE = RD | PC_ADR;
  localparam logic [17:0] FETCH_LD   = LD_IR | INC;
  localparam logic [17:0] LOADS      = LD_IR | LD_AC | LD_ACII | LD_PC;

  // Strobes of each opcode in its completing EXECUTE cycle (JZ entry assumes zero_flag=1).
  logic [17:0] tbl [16];

  function automatic void init_tbl();
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    tbl[0]  = IR_ADR | RD | LD_AC;
    tbl[1]  = LD_ACII;
    tbl[2]  = LD_ACII | S_ACII | PA_ADD;
    tbl[3]  = IR_ADR | WR | S_ACII | PA_AC2;
    tbl[4]  = IR_ADR | WR;
    tbl[5]  = CLR;
    tbl[6]  = LD_AC | S_ACII | SRC_AC | PA_SUB;
    tbl[7]  = IR_ADR | WR;
    tbl[8]  = LD_PC | S_IR;
    tbl[9]  = LD_PC | S_IR;
    tbl[10] = LD_AC | S_ZERO;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom);
  endfunction

  task automatic cyc(input logic rdy, input logic [3:0] opc, input logic zf, input logic rn);
    @(negedge clk);
    mem_ready = rdy;
    op_code   = opc;
    zero_flag = zf;
    run       = rn;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1, r4(), rb(), 1'b0);
    cyc(1'b1, r4(), rb(), 1'b0);
  endtask

  // One full instruction starting at its first FETCH cycle; both instances must agree.
  task automatic do_instr(input int op, input int wf, input int we, input logic zf,
                          input string nm);
    logic [17:0] exp;
    bit          is_mem;
    is_mem = (op == 0) || (op == 3) || (op == 4) || (op == 7);
    for (int i = 0; i <= wf; i++) begin
      cyc(i == wf, r4(), rb(), rb());
      exp = (i == wf) ? (FETCH_BASE | FETCH_LD) : FETCH_BASE;
      n_tests++;
      if (va !== exp) begin
        n_fail++; $display("FAIL %s fetch[%0d] dut_a: got %h expected %h", nm, i, va, exp);
      end
      n_tests++;
      if (vb !== exp) begin
        n_fail++; $display("FAIL %s fetch[%0d] dut_b: got %h expected %h", nm, i, vb, exp);
      end
    end
    cyc(rb(), 4'(op), rb(), rb());
    n_tests++;
    if (va !== 18'h0) begin
      n_fail++; $display("FAIL %s decode dut_a: got %h expected 0", nm, va);
    end
    n_tests++;
    if (vb !== 18'h0) begin
      n_fail++; $display("FAIL %s decode dut_b: got %h expected 0", nm, vb);
    end
    if (is_mem) begin
      for (int i = 0; i <= we; i++) begin
        cyc(i == we, r4(), zf, rb());
        exp = (i == we) ? tbl[op] : (tbl[op] & ~LOADS);
        n_tests++;
        if (va !== exp) begin
          n_fail++; $display("FAIL %s exec op%0d[%0d] dut_a: got %h expected %h", nm, op, i, va, exp);
        end
        n_tests++;
        if (vb !== exp) begin
          n_fail++; $display("FAIL %s exec op%0d[%0d] dut_b: got %h expected %h", nm, op, i, vb, exp);
        end
      end
    end else begin
      cyc(rb(), r4(), zf, rb());
      exp = (op == 8 && !zf) ? 18'h0 : tbl[op];
      n_tests++;
      if (va !== exp) begin
        n_fail++; $display("FAIL %s exec op%0d dut_a: got %h expected %h", nm, op, va, exp);
      end
      n_tests++;
      if (vb !== exp) begin
        n_fail++; $display("FAIL %s exec op%0d dut_b: got %h expected %h", nm, op, vb, exp);
      end
    end
  endtask

  task automatic test_reset();
    cyc(rb(), r4(), rb(), rb());
    n_tests++;
    if (va !== CLR) begin n_fail++; $display("FAIL reset_held: got %h expected %h", va, CLR); end
    reset = 1'b0;
    #1;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) cyc(rb(), r4(), rb(), rb());
      n_tests++;
      if (va !== CLR) begin n_fail++; $display("FAIL reset_cycle%0d dut_a: got %h expected %h", k, va, CLR); end
      n_tests++;
      if (vb !== CLR) begin n_fail++; $display("FAIL reset_cycle%0d dut_b: got %h expected %h", k, vb, CLR); end
    end
    cyc(1'b1, r4(), rb(), 1'b0);
    n_tests++;
    if (va !== (FETCH_BASE | FETCH_LD)) begin
      n_fail++; $display("FAIL reset_first_fetch: got %h expected %h", va, FETCH_BASE | FETCH_LD);
    end
    cyc(rb(), 4'd1, rb(), rb());
    n_tests++;
    if (va !== 18'h0) begin n_fail++; $display("FAIL reset_decode: got %h expected 0", va); end
    cyc(rb(), r4(), rb(), rb());
    n_tests++;
    if (va !== LD_ACII) begin n_fail++; $display("FAIL reset_exec_mov: got %h expected %h", va, LD_ACII); end
  endtask

  task automatic test_program();
    int prog[5] = '{0, 1, 2, 6, 3};
    foreach (prog[i]) do_instr(prog[i], 0, 0, rb(), "program");
  endtask

  task automatic test_fetch_wait();
    do_instr(1, 4, 0, rb(), "fetch_wait");
    do_instr(0, 2, 3, rb(), "lda_wait");
    do_instr(3, 1, 5, rb(), "sta2_wait");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_instr(int'($urandom_range(10, 0)), int'($urandom_range(3, 0)),
               int'($urandom_range(4, 0)), rb(), "random");
    end
  endtask

  task automatic test_jz_halt();
    do_instr(8, 0, 0, 1'b1, "jz_taken");
    do_instr(8, 0, 0, 1'b0, "jz_not_taken");
    do_instr(11, 0, 0, rb(), "halt");
    for (int k = 1; k <= 10; k++) begin
      cyc(rb(), r4(), rb(), k == 10);
      n_tests++;
      if (va !== HALTED) begin n_fail++; $display("FAIL halt_cycle%0d dut_a: got %h expected %h", k, va, HALTED); end
      n_tests++;
      if (vb !== HALTED) begin n_fail++; $display("FAIL halt_cycle%0d dut_b: got %h expected %h", k, vb, HALTED); end
    end
    do_instr(9, 0, 0, rb(), "after_run");
  endtask

  task automatic test_timeout();
    logic [17:0] exp_a;
    cyc(1'b1, r4(), rb(), 1'b0);
    cyc(rb(), 4'd0, rb(), rb());
    for (int k = 1; k <= 21; k++) begin
      cyc(1'b0, r4(), rb(), rb());
      exp_a = (k >= 17) ? ERR : (IR_ADR | RD);
      n_tests++;
      if (va !== exp_a) begin n_fail++; $display("FAIL timeout_cycle%0d dut_a: got %h expected %h", k, va, exp_a); end
      n_tests++;
      if (vb !== (IR_ADR | RD)) begin
        n_fail++; $display("FAIL nolimit_wait%0d dut_b: got %h expected %h", k, vb, IR_ADR | RD);
      end
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (va !== CLR) begin n_fail++; $display("FAIL async_reset dut_a: got %h expected %h", va, CLR); end
    n_tests++;
    if (vb !== CLR) begin n_fail++; $display("FAIL async_reset dut_b: got %h expected %h", vb, CLR); end
    do_reset();
  endtask

  task automatic test_illegal();
    cyc(1'b1, r4(), rb(), 1'b0);
    cyc(rb(), 4'd13, rb(), rb());
    cyc(rb(), r4(), rb(), rb());
    n_tests++;
    if (va !== 18'h0) begin n_fail++; $display("FAIL illegal_exec dut_a: got %h expected 0", va); end
    n_tests++;
    if (vb !== 18'h0) begin n_fail++; $display("FAIL illegal_exec dut_b: got %h expected 0", vb); end
    cyc(1'b1, r4(), rb(), rb());
    n_tests++;
    if (va !== ERR) begin n_fail++; $display("FAIL illegal_trap dut_a: got %h expected %h", va, ERR); end
    n_tests++;
    if (vb !== (FETCH_BASE | FETCH_LD)) begin
      n_fail++; $display("FAIL illegal_nop dut_b: got %h expected %h", vb, FETCH_BASE | FETCH_LD);
    end
    do_reset();
    do_instr(10, 0, 0, rb(), "after_trap");
  endtask

  initial begin
    init_tbl();
    test_reset();
    test_program();
    test_fetch_wait();
    test_random();
    test_jz_halt();
    test_timeout();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
